// File: rtl/qam16_mixer.sv
// qam16_mixer: 16-QAM symbol mapper and carrier mixer.
// Each accepted 4-bit symbol is held for SYM_LEN carrier samples.
// The output is the passband sample I*cos - Q*sin through a 2-stage pipeline.
// Build option: define QAM_GRAY_EN for the Gray level map.
// Without it the natural binary map is used.
module qam16_mixer #(
    parameter int CARRIER_WIDTH = 16,
    parameter int SYM_LEN       = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [3:0]                      sym_data,
    input  logic                            sym_valid,
    output logic                            sym_ready,
    input  logic signed [CARRIER_WIDTH-1:0] cos_wav,
    input  logic signed [CARRIER_WIDTH-1:0] sin_wav,
    output logic signed [CARRIER_WIDTH+2:0] qam_out,
    output logic                            out_valid,
    output logic                            underflow
);
    localparam int PW = CARRIER_WIDTH + 2;
    localparam int OW = CARRIER_WIDTH + 3;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                          state_reg;
    logic [15:0]                     cnt_reg;
    logic                            ready_reg;
    logic                            underflow_reg;
    logic signed [2:0]               lvl_reg [2];   // [0] = I level, [1] = Q level
    logic signed [CARRIER_WIDTH-1:0] carrier [2];   // [0] = cos, [1] = sin
    logic signed [PW-1:0]            prod_next [2];
    logic signed [PW-1:0]            prod_reg [2];
    logic                            act_d1_reg;
    logic                            out_valid_reg;
    logic signed [OW-1:0]            qam_reg;
    logic [15:0]                     sym_last;
    logic                            fire;

    assign sym_last   = 16'(SYM_LEN - 1);
    assign fire       = sym_valid && ready_reg;
    assign carrier[0] = cos_wav;
    assign carrier[1] = sin_wav;

    // Map a 2-bit field onto one of the four amplitude levels.
    function automatic logic signed [2:0] map_level(input logic [1:0] f);
        logic signed [2:0] lvl;
`ifdef QAM_GRAY_EN
        case (f)
            2'b00:   lvl = 3'sb101;  // -3
            2'b01:   lvl = 3'sb111;  // -1
            2'b11:   lvl = 3'sb001;  // +1
            default: lvl = 3'sb011;  // +3
        endcase
`else
        case (f)
            2'b00:   lvl = 3'sb101;  // -3
            2'b01:   lvl = 3'sb111;  // -1
            2'b10:   lvl = 3'sb001;  // +1
            default: lvl = 3'sb011;  // +3
        endcase
`endif
        return lvl;
    endfunction

    // One multiplier lane per quadrature branch; operands sign-extended so the
    // full-width product fits exactly (|3 * -2^(W-1)| < 2^(W+1)).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [PW-1:0] lvl_ext;
            logic signed [PW-1:0] car_ext;
            assign lvl_ext       = {{(PW-3){lvl_reg[gi][2]}}, lvl_reg[gi]};
            assign car_ext       = {{2{carrier[gi][CARRIER_WIDTH-1]}}, carrier[gi]};
            assign prod_next[gi] = lvl_ext * car_ext;
        end
    endgenerate

    // Symbol FSM: level registers, symbol counter, registered ready and underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            ready_reg     <= 1'b0;
            underflow_reg <= 1'b0;
            lvl_reg[0]    <= '0;
            lvl_reg[1]    <= '0;
        end else begin
            underflow_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (fire) begin
                        lvl_reg[0] <= map_level(sym_data[3:2]);
                        lvl_reg[1] <= map_level(sym_data[1:0]);
                        cnt_reg    <= sym_last;
                        ready_reg  <= 1'b0;
                        state_reg  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cnt_reg == 16'd0) begin
                        if (fire) begin
                            // back-to-back symbol, no gap
                            lvl_reg[0] <= map_level(sym_data[3:2]);
                            lvl_reg[1] <= map_level(sym_data[1:0]);
                            cnt_reg    <= sym_last;
                            ready_reg  <= 1'b0;
                        end else begin
                            lvl_reg[0]    <= '0;
                            lvl_reg[1]    <= '0;
                            underflow_reg <= 1'b1;
                            ready_reg     <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end else begin
                        cnt_reg   <= cnt_reg - 16'd1;
                        // ready coincides with the final sample of the symbol
                        ready_reg <= (cnt_reg == 16'd1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Two-stage mixer pipeline with the active flag delayed alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg[0]   <= '0;
            prod_reg[1]   <= '0;
            act_d1_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            qam_reg       <= '0;
        end else begin
            prod_reg[0]   <= prod_next[0];
            prod_reg[1]   <= prod_next[1];
            act_d1_reg    <= (state_reg == ACTIVE);
            out_valid_reg <= act_d1_reg;
            qam_reg       <= {prod_reg[0][PW-1], prod_reg[0]} - {prod_reg[1][PW-1], prod_reg[1]};
        end
    end

    assign sym_ready = ready_reg;
    assign underflow = underflow_reg;
    assign qam_out   = qam_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_qam16_mixer.sv
// Testbench for qam16_mixer: vector table, hand-written corner sequences and
// randomized traffic against a per-cycle behavioural model built from
// "remaining samples of the current symbol" and a history of levels/carriers.
`timescale 1ns/1ps
module tb_qam16_mixer;
    localparam int CW   = 16;
    localparam int L    = 4;
    localparam int NMAX = 8192;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           sym_data;
    logic                 sym_valid;
    logic                 sym_ready;
    logic signed [CW-1:0] cos_wav;
    logic signed [CW-1:0] sin_wav;
    logic signed [CW+2:0] qam_out;
    logic                 out_valid;
    logic                 underflow;

    qam16_mixer #(.CARRIER_WIDTH(CW), .SYM_LEN(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .cos_wav   (cos_wav),
        .sin_wav   (sin_wav),
        .qam_out   (qam_out),
        .out_valid (out_valid),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int cyc   = 0;
    int rem   = 0;      // level-carrying cycles left, including the current one
    bit fresh = 1'b1;   // first cycle after a reset edge: not ready
    bit uf    = 1'b0;
    int cur_i = 0;
    int cur_q = 0;
    int lvl_i_h [NMAX];
    int lvl_q_h [NMAX];
    int cos_h   [NMAX];
    int sin_h   [NMAX];
    bit act_h   [NMAX];
    bit checking = 1'b0;
    bit last_acc;

    // values sampled from the DUT at the last negedge
    logic signed [CW+2:0] s_qam;
    logic                 s_ov;
    logic                 s_ready;
    logic                 s_uf;

    function automatic int level_of(input logic [1:0] f);
`ifdef QAM_GRAY_EN
        case (f)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
`else
        case (f)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b10:   return 1;
            default: return 3;
        endcase
`endif
    endfunction

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic cycle(input bit v, input logic [3:0] d, input int cv, input int sv, input bit r);
        int  exp_q;
        bit  exp_ready;
        @(negedge clk);
        exp_ready = !fresh && (rem <= 1);
        s_qam   = qam_out;
        s_ov    = out_valid;
        s_ready = sym_ready;
        s_uf    = underflow;
        if (checking) begin
            exp_q = (cyc >= 2) ? lvl_i_h[cyc-2] * cos_h[cyc-2] - lvl_q_h[cyc-2] * sin_h[cyc-2] : 0;
            check("qam_out", qam_out, exp_q);
            check("out_valid", out_valid, (cyc >= 2) ? int'(act_h[cyc-2]) : 0);
            check("sym_ready", sym_ready, int'(exp_ready));
            check("underflow", underflow, int'(uf));
        end
        rst       = r;
        sym_valid = v;
        sym_data  = d;
        cos_wav   = CW'(cv);
        sin_wav   = CW'(sv);
        lvl_i_h[cyc] = (rem > 0) ? cur_i : 0;
        lvl_q_h[cyc] = (rem > 0) ? cur_q : 0;
        act_h[cyc]   = (rem > 0);
        cos_h[cyc]   = cv;
        sin_h[cyc]   = sv;
        last_acc = 1'b0;
        if (r) begin
            rem = 0; fresh = 1'b1; uf = 1'b0;
            // reset flushes everything still in flight
            lvl_i_h[cyc] = 0; lvl_q_h[cyc] = 0; act_h[cyc] = 1'b0;
            if (cyc > 0) begin
                lvl_i_h[cyc-1] = 0; lvl_q_h[cyc-1] = 0; act_h[cyc-1] = 1'b0;
            end
        end else begin
            fresh = 1'b0;
            uf    = 1'b0;
            if (v && exp_ready) begin
                rem = L;
                cur_i = level_of(d[3:2]);
                cur_q = level_of(d[1:0]);
                last_acc = 1'b1;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) uf = 1'b1;
            end
        end
        @(posedge clk);
        if (cyc < NMAX - 1) cyc++;
        else begin
            $display("FAIL cycle_budget at cycle %0d: got %0d, required %0d", cyc, cyc, NMAX - 1);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    // Offer a symbol until accepted (bounded).
    task automatic send(input logic [3:0] d, input int cv, input int sv);
        bit ok = 1'b0;
        for (int t = 0; t < 3 * L && !ok; t++) begin
            cycle(1'b1, d, cv, sv, 1'b0);
            ok = last_acc;
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    typedef struct {
        logic [3:0] sym;
        int         cv;
        int         sv;
        int         exp_gray;
        int         exp_bin;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int exp;
        int ov_cnt, uf_cnt, acc_cnt;

        tbl[0] = '{4'b1011,  16384,      0,   49152,  16384};
        tbl[1] = '{4'b0010, -32768,  32767,       3,  65537};
        tbl[2] = '{4'b1000, -32768,  32767,      -3,  65533};
        tbl[3] = '{4'b0101,   1000,    300,    -700,   -700};
        tbl[4] = '{4'b1111,  32767, -32768,   65535, 196605};
        tbl[5] = '{4'b0000,  32767, -32768, -196605, -196605};
        tbl[6] = '{4'b1101,    100,    200,     300,    500};
        tbl[7] = '{4'b1011,    100,      0,     300,    100};

        rst = 1'b1; sym_valid = 1'b0; sym_data = '0; cos_wav = '0; sin_wav = '0;
        cycle(1'b0, 4'h0, 0, 0, 1'b1);
        cycle(1'b0, 4'h0, 0, 0, 1'b1);
        checking = 1'b1;
        // reset state, then ready rises one cycle after release
        cycle(1'b0, 4'h0, 0, 0, 1'b0);
        check("reset_qam", s_qam, 0);
        check("reset_ready", s_ready, 0);
        cycle(1'b0, 4'h0, 0, 0, 1'b0);
        check("ready_after_release", s_ready, 1);

        // table: steady carriers, check qam two cycles after acceptance
        for (int i = 0; i < 8; i++) begin
`ifdef QAM_GRAY_EN
            exp = tbl[i].exp_gray;
`else
            exp = tbl[i].exp_bin;
`endif
            send(tbl[i].sym, tbl[i].cv, tbl[i].sv);
            cycle(1'b0, 4'h0, tbl[i].cv, tbl[i].sv, 1'b0);
            cycle(1'b0, 4'h0, tbl[i].cv, tbl[i].sv, 1'b0);
            cycle(1'b0, 4'h0, tbl[i].cv, tbl[i].sv, 1'b0);
            check($sformatf("table%0d_qam", i), s_qam, exp);
            for (int t = 0; t < L + 3; t++) cycle(1'b0, 4'h0, tbl[i].cv, tbl[i].sv, 1'b0);
        end

        // single symbol: out_valid for exactly L cycles, one underflow pulse
        ov_cnt = 0; uf_cnt = 0;
        send(4'b1011, 16384, 0);
        for (int t = 0; t < L + 6; t++) begin
            cycle(1'b0, 4'h0, 16384, 0, 1'b0);
            ov_cnt += int'(s_ov);
            uf_cnt += int'(s_uf);
        end
        check("single_ov_len", ov_cnt, L);
        check("single_uf_pulses", uf_cnt, 1);

        // continuous valid: ready 1 in L, no gap, no underflow
        acc_cnt = 0; ov_cnt = 0; uf_cnt = 0;
        for (int t = 0; t < 10 * L; t++) begin
            cycle(1'b1, 4'($urandom_range(0, 15)), 12345, -2222, 1'b0);
            acc_cnt += int'(last_acc);
            uf_cnt  += int'(s_uf);
            if (t >= 3) ov_cnt += int'(s_ov);
        end
        check("stream_accepts", acc_cnt, 10);
        check("stream_underflow", uf_cnt, 0);
        check("stream_ov_gapless", ov_cnt, 10 * L - 3);
        for (int t = 0; t < L + 4; t++) cycle(1'b0, 4'h0, 0, 0, 1'b0);

        // reset mid-symbol: flushed, no underflow, ready one cycle after release
        send(4'b1111, 20000, 20000);
        cycle(1'b0, 4'h0, 20000, 20000, 1'b0);
        cycle(1'b0, 4'h0, 20000, 20000, 1'b1);
        cycle(1'b0, 4'h0, 20000, 20000, 1'b0);
        check("midrst_qam", s_qam, 0);
        check("midrst_ov", s_ov, 0);
        check("midrst_uf", s_uf, 0);
        check("midrst_ready", s_ready, 0);
        cycle(1'b0, 4'h0, 20000, 20000, 1'b0);
        check("midrst_ready_after", s_ready, 1);
        cycle(1'b0, 4'h0, 20000, 20000, 1'b0);
        check("midrst_no_uf_later", s_uf, 0);

        // randomized traffic against the model
        for (int t = 0; t < 2500; t++) begin
            cycle(($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768,
                  ($urandom_range(0, 199) == 0));
        end
        for (int t = 0; t < L + 4; t++) cycle(1'b0, 4'h0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qam16_mixer.md
# qam16_mixer

16-QAM symbol mapper and carrier mixer. It accepts 4-bit symbols over a valid/ready handshake and maps each one to I/Q amplitude levels. Each symbol is held for a fixed number of carrier samples and produces the passband sample I·cos − Q·sin. The block sits directly downstream of the two sine-table NCO instances: the cosine-phase instance feeds `cos_wav` and the sine-phase instance feeds `sin_wav`. Its output goes to the DAC interface.

## Interface
- `CARRIER_WIDTH`, 16: width of signed two's-complement carrier samples.
- `SYM_LEN`, 64: carrier samples (clock cycles) per symbol; legal range 2..65535.
- `clk`  in  1  sole clock; carriers, symbols and output are all in this domain.
- `rst`  in  1  synchronous, active-high reset.
- `sym_data`  in  4  symbol; [3:2] selects I level, [1:0] selects Q level.
- `sym_valid`  in  1  `sym_data` is valid.
- `sym_ready`  out  1  block accepts a symbol at this edge when `sym_valid` is also high.
- `cos_wav`  in  CARRIER_WIDTH  signed cosine carrier sample.
- `sin_wav`  in  CARRIER_WIDTH  signed sine carrier sample.
- `qam_out`  out  CARRIER_WIDTH+3  signed modulated sample.
- `out_valid`  out  1  `qam_out` carries symbol energy (not idle zeros).
- `underflow`  out  1  one-cycle pulse: symbol period ended with no next symbol available.

## Operation
- Level map, per 2-bit field: 00→−3, 01→−1, 11→+1, 10→+3 (Gray; see Configuration). Levels are held in 3-bit signed registers `i_lvl` and `q_lvl`.
- State machine:
  - IDLE
    - `i_lvl` = `q_lvl` = 0; `sym_ready` = 1.
    - On `sym_valid`: load levels, load counter to SYM_LEN−1, go to ACTIVE.
  - ACTIVE
    - Counter decrements each cycle.
    - `sym_ready` = 1 only when counter == 0.
    - At counter == 0 with `sym_valid`: load the new levels and reload the counter. Symbols run back-to-back with no gap.
    - At counter == 0 without `sym_valid`: go to IDLE, clear the levels, pulse `underflow`.
- Handshake: transfer occurs at an edge where both `sym_valid` and `sym_ready` are high. `sym_ready` depends only on state and counter, never combinationally on `sym_valid`.
- Arithmetic:
  - Stage 1 registers `p_i = i_lvl*cos_wav` and `p_q = q_lvl*sin_wav`, each CARRIER_WIDTH+2 bits signed.
  - Stage 2 registers `qam_out = p_i − p_q`, sign-extended to CARRIER_WIDTH+3.
  - Worst-case magnitude is 6·2^(CARRIER_WIDTH−1), so no saturation logic is needed; overflow is impossible.
- `out_valid` is the ACTIVE flag delayed through the same 2 stages.

## Timing
- Reset (sampled at `clk` edge while `rst`=1):
  - state = IDLE; counter = 0; levels = 0; pipeline = 0.
  - `qam_out` = 0, `out_valid` = 0, `underflow` = 0, `sym_ready` = 0.
  - `sym_ready` rises the first cycle after `rst` deasserts.
- Latency:
  - A symbol accepted at edge k drives levels from edge k.
  - The carrier sample present in cycle k+1 (after edge k) contributes to `qam_out` registered at edge k+2.
  - In general, a carrier sample present in cycle n appears at `qam_out` 2 edges later.
- Symbol period: exactly SYM_LEN cycles of non-zero levels per accepted symbol.
- Boundary conditions:
  - `sym_valid` during ACTIVE with counter ≠ 0: not accepted; upstream must hold the symbol.
  - Underflow: `underflow` is high in the cycle after the final-sample edge. `out_valid` falls 2 cycles after the levels clear.
  - Reset mid-symbol: the symbol is abandoned and the pipeline is flushed. `qam_out` = 0 on the next cycle; no `underflow` pulse.
  - SYM_LEN = 2: alternate ready/not-ready cycles; sustained throughput of one symbol per 2 cycles.

## Configuration
- `QAM_GRAY_EN` defined: Gray map 00→−3, 01→−1, 11→+1, 10→+3 (default build).
- Undefined: natural binary map 00→−3, 01→−1, 10→+1, 11→+3.
- Nothing else changes.

## Test plan
- Reset, then CARRIER_WIDTH=16, `cos_wav`=16384, `sin_wav`=0, send 4'b1011 (Gray) → `qam_out`=49152 two cycles after acceptance, `out_valid`=1 for exactly SYM_LEN cycles.
- `cos_wav`=−32768, `sin_wav`=32767, symbol 4'b0010 (I=−3, Q=+3) → `qam_out`=98304−98301=3; then symbol 4'b1000 (I=+3, Q=−3) → `qam_out`=−98304+98301=−3. Both verify sign handling and full-range width.
- Continuous `sym_valid` with SYM_LEN=4 → `sym_ready` high 1 cycle in 4, no gap in `out_valid`, `underflow` never asserted.
- Single symbol then `sym_valid`=0 → `underflow` pulses once after SYM_LEN cycles; `qam_out` returns to 0 two cycles later.
- Assert `rst` mid-symbol → next cycle `qam_out`=0, `out_valid`=0, `underflow`=0; `sym_ready`=1 one cycle after release.
- Build without `QAM_GRAY_EN`, symbol 4'b1011 with `cos_wav`=100, `sin_wav`=0 → `qam_out`=100 (I=+1).
